priority_dc: RTL and testbench

PRIORITY_DC -- requirements
Module: priority_dc

---
 rtl/priority_dc.sv | 133 +++++++++++++
 tb/tb_priority_dc.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_dc.sv
// priority_dc
// Binary index to one-hot decoder behind a two-entry FIFO with
// valid/ready handshakes on both sides.
//
// The head register drives out directly. The skid register holds a second
// index while the consumer stalls. Indices leave in the order they were
// accepted. An index with no matching output line is still queued. It
// decodes to all-zero and raises err for the single cycle after it is
// accepted.
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   synchronous, active-high reset
//   in        in   [IN_WIDTH-1:0] binary index
//   in_valid  in   in carries an index
//   in_ready  out  an index can be accepted this cycle (registered)
//   out       out  [OUT_WIDTH-1:0] one-hot decode of the head entry
//   out_valid out  out holds a decode
//   out_ack   in   consumer takes out this cycle
//   err       out  one-cycle pulse: last accepted index was out of range
module priority_dc #(
  parameter  int OUT_WIDTH = 4,
  localparam int IN_WIDTH  = $clog2(OUT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ack,
  output logic                 err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t               state_reg;
  logic [OUT_WIDTH-1:0] out_reg;
  logic [OUT_WIDTH-1:0] skid_reg;
  logic                 ready_reg;
  logic                 valid_reg;
  logic                 err_reg;

  logic [OUT_WIDTH-1:0] dec_in;
  logic                 in_bad;
  logic                 in_xfer;
  logic                 out_xfer;

  // Decode the incoming index once. Entries are stored already decoded, so
  // moving skid to head is a plain copy.
  genvar gi;
  generate
    for (gi = 0; gi < OUT_WIDTH; gi++) begin : g_dec
      assign dec_in[gi] = (in == IN_WIDTH'(gi));
    end
  endgenerate

  // No line matched, so the index is beyond the last output.
  assign in_bad   = ~|dec_in;

  // Handshakes use only registered flags. That way ready never depends
  // combinationally on valid, and ack is ignored while nothing is held.
  assign in_xfer  = in_valid && ready_reg;
  assign out_xfer = valid_reg && out_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      out_reg   <= '0;
      skid_reg  <= '0;
      ready_reg <= 1'b0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= in_xfer && in_bad;
      case (state_reg)
        EMPTY: begin
          ready_reg <= 1'b1;
          if (in_xfer) begin
            out_reg   <= dec_in;
            valid_reg <= 1'b1;
            state_reg <= ONE;
          end
        end
        ONE: begin
          case ({in_xfer, out_xfer})
            2'b10: begin
              // Consumer stalled: park the new index behind the head.
              skid_reg  <= dec_in;
              ready_reg <= 1'b0;
              state_reg <= TWO;
            end
            2'b01: begin
              out_reg   <= '0;
              valid_reg <= 1'b0;
              state_reg <= EMPTY;
            end
            2'b11: begin
              // Head leaves as the new index arrives: pass straight through.
              out_reg <= dec_in;
            end
            default: ;
          endcase
        end
        TWO: begin
          // ready is low here, so only the output side can move.
          if (out_xfer) begin
            out_reg   <= skid_reg;
            ready_reg <= 1'b1;
            state_reg <= ONE;
          end
        end
        default: begin
          state_reg <= EMPTY;
          out_reg   <= '0;
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = ready_reg;
  assign out       = out_reg;
  assign out_valid = valid_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_priority_dc.sv
// Bench for priority_dc. It runs two instances side by side: OUT_WIDTH=4
// (index 0) and OUT_WIDTH=5 (index 1). Drivers push the expected decode
// into a per-instance queue when an index is accepted. A monitor on the
// falling edge compares the head against the queue and pops it on every
// output transfer. The monitor also checks the err timing, the all-zero
// idle output, stability while stalled, and the values after reset.
module tb_priority_dc;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] idx [2];
  logic       iv  [2];
  logic       ack [2];

  logic [3:0] out4;
  logic [4:0] out5;
  logic [7:0] outw [2];
  logic       rdy  [2];
  logic       vld  [2];
  logic       errw [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  priority_dc #(.OUT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in(idx[0][1:0]), .in_valid(iv[0]), .in_ready(rdy[0]),
    .out(out4), .out_valid(vld[0]), .out_ack(ack[0]), .err(errw[0])
  );

  priority_dc #(.OUT_WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .in(idx[1]), .in_valid(iv[1]), .in_ready(rdy[1]),
    .out(out5), .out_valid(vld[1]), .out_ack(ack[1]), .err(errw[1])
  );

  assign outw[0] = {4'b0, out4};
  assign outw[1] = {3'b0, out5};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model of the decode: one-hot when the index is in range, zero otherwise.
  function automatic logic [7:0] dec(input int w, input logic [2:0] i);
    return (int'(i) < w) ? (8'd1 << i) : 8'h00;
  endfunction

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_mon
    localparam int W = (gi == 0) ? 4 : 5;
    logic [7:0] q [$];
    logic       pend = 1'b0;
    logic       prev_rst = 1'b0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_out = 8'h00;

    always @(negedge clk) begin
      if (prev_rst) begin
        chk("rst_out", outw[gi], 8'h00);
        chk("rst_valid", 8'(vld[gi]), 8'h00);
        chk("rst_ready", 8'(rdy[gi]), 8'h00);
        chk("rst_err", 8'(errw[gi]), 8'h00);
      end else if (!rst) begin
        chk("err_pulse", 8'(errw[gi]), 8'(pend));
        if (!vld[gi]) chk("idle_out_zero", outw[gi], 8'h00);
        if (prev_hold) begin
          chk("stall_out_stable", outw[gi], prev_out);
          chk("stall_valid_stable", 8'(vld[gi]), 8'h01);
        end
        if (vld[gi]) begin
          if (q.size() == 0) begin
            chk("spurious_out_valid", 8'(vld[gi]), 8'h00);
          end else begin
            chk("sb_out", outw[gi], q[0]);
            if (ack[gi]) void'(q.pop_front());
          end
        end
      end
      pend      = iv[gi] && rdy[gi] && !rst && (int'(idx[gi]) >= W);
      prev_hold = vld[gi] && !ack[gi] && !rst;
      prev_out  = outw[gi];
      prev_rst  = rst;
    end
  end

  task automatic sb_push(input int d, input logic [7:0] e);
    if (d == 0) g_mon[0].q.push_back(e);
    else        g_mon[1].q.push_back(e);
    $display("push dut%0d expect %0h", d, e);
  endtask

  // Offer one index until it is accepted (bounded), then drop in_valid.
  task automatic push(input int d, input logic [2:0] i, input logic [7:0] e);
    int n = 0;
    iv[d]  = 1'b1;
    idx[d] = i;
    while (!rdy[d] && n < 50) begin
      step();
      n++;
    end
    chk("push_accept_timeout", 8'(rdy[d]), 8'h01);
    if (rdy[d]) sb_push(d, e);
    step();
    iv[d] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int cyc;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; idx[d] = 3'd0; ack[d] = 1'b0;
    end
    step();
    step();
    chk("reset_ready", 8'(rdy[0]), 8'h00);
    chk("reset_valid", 8'(vld[0]), 8'h00);
    rst = 1'b0;
    step();
    chk("ready_after_reset0", 8'(rdy[0]), 8'h01);
    chk("ready_after_reset1", 8'(rdy[1]), 8'h01);

    // Single index, latency one, consumer ready.
    ack[0] = 1'b1;
    push(0, 3'd2, 8'h04);
    chk("t1_out", outw[0], 8'h04);
    chk("t1_valid", 8'(vld[0]), 8'h01);
    step();
    chk("t1_valid_drop", 8'(vld[0]), 8'h00);
    ack[0] = 1'b0;

    // Fill both entries with the consumer stalled; the third index waits.
    push(0, 3'd0, 8'h01);
    push(0, 3'd1, 8'h02);
    chk("t2_ready_full", 8'(rdy[0]), 8'h00);
    iv[0] = 1'b1; idx[0] = 3'd3;
    step();
    step();
    chk("t2_still_full", 8'(rdy[0]), 8'h00);
    chk("t2_head", outw[0], 8'h01);
    iv[0] = 1'b0;
    ack[0] = 1'b1; step(); ack[0] = 1'b0;
    chk("t2_second", outw[0], 8'h02);
    chk("t2_ready_back", 8'(rdy[0]), 8'h01);
    step();
    ack[0] = 1'b1; step(); ack[0] = 1'b0;
    chk("t2_empty", 8'(vld[0]), 8'h00);

    // State ONE: simultaneous push and pop reloads the head.
    push(0, 3'd1, 8'h02);
    chk("t3_ready", 8'(rdy[0]), 8'h01);
    iv[0] = 1'b1; idx[0] = 3'd3; ack[0] = 1'b1;
    sb_push(0, 8'h08);
    step();
    iv[0] = 1'b0; ack[0] = 1'b0;
    chk("t3_out", outw[0], 8'h08);
    chk("t3_valid", 8'(vld[0]), 8'h01);
    chk("t3_ready_one", 8'(rdy[0]), 8'h01);
    ack[0] = 1'b1; step(); ack[0] = 1'b0;

    // Index is ignored without in_valid; ack is ignored while empty.
    idx[0] = 3'd3; ack[0] = 1'b1;
    step(); step(); step();
    ack[0] = 1'b0;
    chk("t4_no_valid", 8'(vld[0]), 8'h00);

    // Full throughput with the consumer always acking.
    ack[0] = 1'b1;
    iv[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idx[0] = 3'(i % 4);
      chk("t5_ready_stream", 8'(rdy[0]), 8'h01);
      sb_push(0, 8'd1 << (i % 4));
      step();
    end
    iv[0] = 1'b0;
    step();
    step();
    ack[0] = 1'b0;

    // OUT_WIDTH=5: out-of-range index, then the top line.
    push(1, 3'd6, 8'h00);
    chk("t6_err", 8'(errw[1]), 8'h01);
    chk("t6_out_zero", outw[1], 8'h00);
    chk("t6_valid", 8'(vld[1]), 8'h01);
    step();
    chk("t6_err_one_cycle", 8'(errw[1]), 8'h00);
    chk("t6_ready", 8'(rdy[1]), 8'h01);
    iv[1] = 1'b1; idx[1] = 3'd4; ack[1] = 1'b1;
    sb_push(1, 8'h10);
    step();
    iv[1] = 1'b0; ack[1] = 1'b0;
    chk("t6_out_top", outw[1], 8'h10);
    chk("t6_err_clear", 8'(errw[1]), 8'h00);
    ack[1] = 1'b1; step(); ack[1] = 1'b0;

    // Reset from TWO discards both entries.
    push(0, 3'd1, 8'h02);
    push(0, 3'd2, 8'h04);
    chk("t7_full", 8'(rdy[0]), 8'h00);
    rst = 1'b1;
    ack[0] = 1'b1;
    g_mon[0].q.delete();
    g_mon[1].q.delete();
    step();
    ack[0] = 1'b0;
    chk("t7_rst_out", outw[0], 8'h00);
    chk("t7_rst_valid", 8'(vld[0]), 8'h00);
    chk("t7_rst_ready", 8'(rdy[0]), 8'h00);
    rst = 1'b0;
    step();
    chk("t7_ready_after", 8'(rdy[0]), 8'h01);
    push(0, 3'd3, 8'h08);
    chk("t7_fresh_out", outw[0], 8'h08);
    ack[0] = 1'b1; step(); ack[0] = 1'b0;

    // Random traffic on both instances.
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      for (int d = 0; d < 2; d++) begin
        iv[d]  = 1'($urandom_range(0, 1));
        idx[d] = (d == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
        ack[d] = 1'($urandom_range(0, 1));
        if (iv[d] && rdy[d]) begin
          sb_push(d, dec((d == 0) ? 4 : 5, idx[d]));
          if (d == 0) acc++;
        end
      end
      step();
      cyc++;
    end
    chk("rand_count_reached", 8'(acc >= 1000), 8'h01);

    // Drain.
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ack[d] = 1'b1;
    end
    cyc = 0;
    while ((g_mon[0].q.size() != 0 || g_mon[1].q.size() != 0) && cyc < 20) begin
      step();
      cyc++;
    end
    step();
    chk("drain_sb0_empty", 8'(g_mon[0].q.size()), 8'h00);
    chk("drain_sb1_empty", 8'(g_mon[1].q.size()), 8'h00);
    chk("drain_valid0", 8'(vld[0]), 8'h00);
    chk("drain_valid1", 8'(vld[1]), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
